// File: rtl/ibr_bcm_engine_if.sv
// Streaming and cipher-core bundle for the block-cipher mode engine.
// master = engine side, slave = host/core side.
interface ibr_bcm_engine_if #(
  parameter int BLOCK_W = 128
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               core_start;
  logic               core_encrypt;
  logic [BLOCK_W-1:0] core_data;
  logic               core_done;
  logic [BLOCK_W-1:0] core_result;

  modport master (
    input  in_valid, in_data,
    input  out_ready,
    input  core_done, core_result,
    output in_ready,
    output out_valid, out_data,
    output core_start, core_encrypt,
    output core_data
  );

  modport slave (
    output in_valid, in_data,
    output out_ready,
    output core_done, core_result,
    input  in_ready,
    input  out_valid, out_data,
    input  core_start, core_encrypt,
    input  core_data
  );
endinterface

// File: rtl/ibr_bcm_engine.sv
// Block-cipher mode-of-operation engine (ECB/CBC/CFB/OFB/CTR).
// Drives an external start/done cipher core; chain persists.
module ibr_bcm_engine #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 64
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic [2:0]         mode,
  input  logic               encrypt,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  ibr_bcm_engine_if.master   bus,
  output logic               busy,
  output logic               mode_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [BLOCK_W-1:0] LOW_MASK =
    {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);
  localparam logic [BLOCK_W-1:0] ONE =
    {{(BLOCK_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic               enc_q, enc_d;
  logic [BLOCK_W-1:0] in_q, in_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               cst_q, cst_d;
  logic               cenc_q, cenc_d;
  logic [BLOCK_W-1:0] cdat_q, cdat_d;
  logic               rdy_q, rdy_d;

  logic               accept;
  logic [BLOCK_W-1:0] res;
  logic [BLOCK_W-1:0] ctr_nx;
  logic m_ecb, m_cbc, m_cfb, m_ofb, m_ctr;

  assign mode_err      = (mode >= 3'd5);
  assign bus.in_ready  = rdy_q && !mode_err;
  assign accept        = bus.in_valid && bus.in_ready;
  assign res           = bus.core_result;
  assign busy          = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_q;
  assign bus.core_start   = cst_q;
  assign bus.core_encrypt = cenc_q;
  assign bus.core_data    = cdat_q;

  // counter increments low CTR_W bits only, no carry out
  assign ctr_nx = (chain_q & ~LOW_MASK)
                | ((chain_q + ONE) & LOW_MASK);

  assign m_ecb = (mode_q == 3'd0);
  assign m_cbc = (mode_q == 3'd1);
  assign m_cfb = (mode_q == 3'd2);
  assign m_ofb = (mode_q == 3'd3);
  assign m_ctr = (mode_q == 3'd4);

  // next-state, core issue and chaining update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    enc_d   = enc_q;
    in_d    = in_q;
    chain_d = chain_q;
    out_d   = out_q;
    cst_d   = 1'b0;
    cenc_d  = cenc_q;
    cdat_d  = cdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (iv_load) chain_d = iv;
        if (accept) begin
          mode_d  = mode;
          enc_d   = encrypt;
          in_d    = bus.in_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cst_d   = 1'b1;
        cenc_d  = 1'b1;
        cdat_d  = chain_q;
        state_d = S_WAIT;
        unique case (1'b1)
          m_ecb: begin
            cenc_d = enc_q;
            cdat_d = in_q;
          end
          m_cbc: begin
            cenc_d = enc_q;
            cdat_d = enc_q ? (in_q ^ chain_q)
                           : in_q;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (bus.core_done) begin
          state_d = S_OUT;
          out_d   = res ^ in_q;
          unique case (1'b1)
            m_ecb: out_d = res;
            m_cbc: begin
              if (enc_q) begin
                out_d   = res;
                chain_d = res;
              end else begin
                out_d   = res ^ chain_q;
                chain_d = in_q;
              end
            end
            m_cfb: chain_d = enc_q ? (res ^ in_q)
                                   : in_q;
            m_ofb: chain_d = res;
            m_ctr: chain_d = ctr_nx;
            default: out_d = res;
          endcase
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  // state and datapath registers
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_IDLE;
      mode_q  <= 3'd0;
      enc_q   <= 1'b0;
      in_q    <= '0;
      chain_q <= '0;
      out_q   <= '0;
      cst_q   <= 1'b0;
      cenc_q  <= 1'b0;
      cdat_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      enc_q   <= enc_d;
      in_q    <= in_d;
      chain_q <= chain_d;
      out_q   <= out_d;
      cst_q   <= cst_d;
      cenc_q  <= cenc_d;
      cdat_q  <= cdat_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_ibr_bcm_engine.sv
// Randomized self-checking bench for ibr_bcm_engine.
// Stub core: result = data ^ 0F..0F, 3-cycle latency.
module tb_ibr_bcm_engine;

  localparam int BW = 128;
  localparam logic [BW-1:0] M = {16{8'h0F}};

  logic          Clk;
  logic          RstN;
  logic [2:0]    mode;
  logic          encrypt;
  logic          iv_load;
  logic [BW-1:0] iv;
  logic          busy;
  logic          mode_err;

  ibr_bcm_engine_if #(.BLOCK_W(BW)) bus ();

  ibr_bcm_engine #(
    .BLOCK_W(BW),
    .CTR_W  (64)
  ) dut (
    .Clk     (Clk),
    .RstN    (RstN),
    .mode    (mode),
    .encrypt (encrypt),
    .iv_load (iv_load),
    .iv      (iv),
    .bus     (bus.master),
    .busy    (busy),
    .mode_err(mode_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [2:0]    dpipe = '0;
  logic [BW-1:0] rpipe [3];
  logic          inj_done;

  always @(posedge Clk) begin
    dpipe    <= {dpipe[1:0], bus.core_start};
    rpipe[0] <= bus.core_data ^ M;
    rpipe[1] <= rpipe[0];
    rpipe[2] <= rpipe[1];
  end

  assign bus.core_done   = dpipe[2] | inj_done;
  assign bus.core_result = inj_done ? ~rpipe[2]
                                    : rpipe[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  logic [BW-1:0] m_chain;

  task automatic model_block(
    input  logic [2:0]    md,
    input  logic          enc,
    input  logic [BW-1:0] din,
    output logic          ce,
    output logic [BW-1:0] cd,
    output logic [BW-1:0] o
  );
    logic [BW-1:0] ks;
    ce = 1'b1;
    cd = m_chain;
    ks = m_chain ^ M;
    o  = ks ^ din;
    case (md)
      3'd0: begin
        ce = enc;
        cd = din;
        o  = din ^ M;
      end
      3'd1: begin
        ce = enc;
        if (enc) begin
          cd = din ^ m_chain;
          o  = cd ^ M;
          m_chain = o;
        end else begin
          cd = din;
          o  = (din ^ M) ^ m_chain;
          m_chain = din;
        end
      end
      3'd2: m_chain = enc ? o : din;
      3'd3: m_chain = ks;
      default: begin
        m_chain[63:0] = m_chain[63:0] + 64'd1;
      end
    endcase
  endtask

  task automatic run_block(
    input  logic [2:0]    md,
    input  logic          enc,
    input  logic          ivl,
    input  logic [BW-1:0] ivv,
    input  logic [BW-1:0] din,
    input  int            bp,
    input  logic          inj,
    output logic [BW-1:0] gout,
    output logic [BW-1:0] gcd
  );
    logic          ece;
    logic [BW-1:0] ecd, eo, hold;
    int t;
    gout = '0;
    gcd  = '0;
    @(negedge Clk);
    mode         = md;
    encrypt      = enc;
    iv_load      = ivl;
    iv           = ivv;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 50) begin
      chk("accept_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      iv_load = 1'b0;
      return;
    end
    if (ivl) m_chain = ivv;
    model_block(md, enc, din, ece, ecd, eo);
    @(negedge Clk);
    bus.in_valid = 1'b0;
    iv_load      = 1'b0;
    mode         = 3'($urandom_range(0, 4));
    encrypt      = ~enc;
    bus.in_data  = {$urandom, $urandom,
                    $urandom, $urandom};
    iv           = {$urandom, $urandom,
                    $urandom, $urandom};
    chk("in_ready_after_acc", bus.in_ready, 1'b0);
    @(negedge Clk);
    chk("core_start_hi", bus.core_start, 1'b1);
    chk("core_data", bus.core_data, ecd);
    chk("core_enc", bus.core_encrypt, ece);
    gcd = bus.core_data;
    @(negedge Clk);
    chk("core_start_lo", bus.core_start, 1'b0);
    t = 1;
    while (!bus.out_valid && t < 50) begin
      @(negedge Clk);
      t++;
    end
    chk("out_latency", t, 4);
    if (!bus.out_valid) return;
    hold = bus.out_data;
    if (inj) begin
      inj_done = 1'b1;
      @(negedge Clk);
      inj_done = 1'b0;
      chk("second_done", bus.out_data, hold);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge Clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_stable", bus.out_data, hold);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    chk("out_data", bus.out_data, eo);
    gout = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_data"}, bus.out_data, '0);
    chk({tag, "_core_start"}, bus.core_start, 1'b0);
    chk({tag, "_core_enc"}, bus.core_encrypt, 1'b0);
    chk({tag, "_core_data"}, bus.core_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [BW-1:0] o1, o2, gd, go;

  initial begin
    RstN          = 1'b0;
    mode          = 3'd0;
    encrypt       = 1'b1;
    iv_load       = 1'b0;
    iv            = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    inj_done      = 1'b0;
    m_chain       = '0;

    repeat (2) @(negedge Clk);
    chk_zero("rst");
    RstN = 1'b1;
    chk("rdy_at_release", bus.in_ready, 1'b0);
    @(negedge Clk);
    chk("rdy_after_edge", bus.in_ready, 1'b1);

    run_block(3'd0, 1'b1, 1'b0, '0,
              128'h1, 0, 1'b0, go, gd);
    chk("ecb_const", go, {M[BW-1:8], 8'h0E});

    run_block(3'd1, 1'b1, 1'b1, 128'hFF,
              128'h01, 0, 1'b0, o1, gd);
    chk("cbc_cd1", gd, 128'hFE);
    run_block(3'd1, 1'b1, 1'b0, '0,
              128'h02, 0, 1'b0, o2, gd);
    chk("cbc_cd2", gd, {M[BW-1:8], 8'hF1} ^ 128'h02);
    run_block(3'd1, 1'b0, 1'b1, 128'hFF,
              o1, 0, 1'b0, go, gd);
    chk("cbc_dec1", go, 128'h01);
    run_block(3'd1, 1'b0, 1'b0, '0,
              o2, 0, 1'b0, go, gd);
    chk("cbc_dec2", go, 128'h02);

    run_block(3'd4, 1'b1, 1'b1,
              {64'h5, 64'hFFFF_FFFF_FFFF_FFFF},
              {$urandom, $urandom, $urandom, $urandom},
              0, 1'b0, go, gd);
    run_block(3'd4, 1'b1, 1'b0, '0,
              {$urandom, $urandom, $urandom, $urandom},
              0, 1'b0, go, gd);
    chk("ctr_wrap", gd, {64'h5, 64'h0});

    run_block(3'd0, 1'b1, 1'b0, '0,
              128'hABCD, 5, 1'b0, go, gd);
    run_block(3'd3, 1'b1, 1'b0, '0,
              128'h1234, 2, 1'b1, go, gd);

    @(negedge Clk);
    inj_done = 1'b1;
    @(negedge Clk);
    inj_done = 1'b0;
    @(negedge Clk);
    chk("idle_done_valid", bus.out_valid, 1'b0);
    chk("idle_done_busy", busy, 1'b0);

    mode         = 3'd0;
    encrypt      = 1'b1;
    bus.in_data  = 128'h55;
    bus.in_valid = 1'b1;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    @(negedge Clk);
    chk("rst_wait_start", bus.core_start, 1'b1);
    @(negedge Clk);
    RstN = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge Clk);
    RstN    = 1'b1;
    m_chain = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("post_rst_valid", bus.out_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    mode         = 3'd6;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("merr_flag", mode_err, 1'b1);
      chk("merr_rdy", bus.in_ready, 1'b0);
      chk("merr_start", bus.core_start, 1'b0);
      chk("merr_busy", busy, 1'b0);
    end
    bus.in_valid = 1'b0;
    mode         = 3'd0;
    @(negedge Clk);
    chk("merr_clear", mode_err, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_block(3'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                {$urandom, $urandom,
                 $urandom, $urandom},
                {$urandom, $urandom,
                 $urandom, $urandom},
                $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0),
                go, gd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
